// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone register slave and its register bank.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DRAIN
    } wb_state_t;

    localparam int WB_ADDR_LSB = 2;

    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/wb_reg_bank.sv
// Word register bank with byte-lane writes, read-only slots fed from the fabric
// and a one-cycle write strobe per register.
module wb_reg_bank
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter int IDX_W = idx_width(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_sel,
    input  logic [IDX_W-1:0]               rd_idx,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [DATA_WIDTH-1:0]          rd_value,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int SEL_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_en) begin
                wr_pulse[wr_idx] <= 1'b1;
                for (int b = 0; b < SEL_W; b++) begin
                    if (wr_sel[b]) begin
                        regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read-only slots are never stored here; they always show zero on reg_out.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
        end
    end

    always_comb begin
        rd_value = regs[rd_idx];
        if (RO_MASK[rd_idx]) begin
            rd_value = reg_in[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone register slave: request FSM, address decode and registered ack/err/rdata
// in front of the wb_reg_bank register file.
module wb_reg_slave
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter int WAIT_STATES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cyc,
    input  logic                           stb,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        sel,
    output logic                           stall,
    output logic                           ack,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           err,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [SEL_W-1:0]      lat_sel;

    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [SEL_W-1:0]      cur_sel;

    logic [IDX_W-1:0]      idx;
    logic                  dec_err;
    logic                  enter_resp;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_value;

    // With zero wait states the response is launched from IDLE, so the live bus
    // fields must be used instead of the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_sel   = sel;
        end else begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_sel   = lat_sel;
        end
    end

    assign idx     = cur_addr[WB_ADDR_LSB +: IDX_W];
    assign dec_err = (cur_addr[WB_ADDR_LSB-1:0] != '0)
                  || ((cur_addr >> (WB_ADDR_LSB + IDX_W)) != '0)
                  || (cur_we && RO_MASK[idx]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cyc && stb) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = DRAIN;
            DRAIN:   if (!stb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_sel   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && cyc && stb) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_sel   <= sel;
            end
        end
    end

    // Responses are registered on the edge that enters RESP, so a reset on that
    // edge suppresses both the pulse and the register commit.
    assign enter_resp = (state_d == RESP);
    assign commit     = enter_resp && cur_we && !dec_err;
    assign stall      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (enter_resp) begin
                if (dec_err) begin
                    err   <= 1'b1;
                    rdata <= '0;
                end else begin
                    ack <= 1'b1;
                    if (!cur_we) begin
                        rdata <= rd_value;
                    end
                end
            end
        end
    end

    wb_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (commit),
        .wr_idx   (idx),
        .wr_data  (cur_wdata),
        .wr_sel   (cur_sel),
        .rd_idx   (idx),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .rd_value (rd_value),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: two instances (1 and 3 wait states) driven by a simple
// Wishbone master and checked against a word/byte-level register model.
module tb_wb_reg_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO1 = 16'h0001;
    localparam logic [NR-1:0] RO3 = 16'h8001;

    logic clk = 1'b0;
    logic rst;
    logic cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0] sel;
    logic target;

    logic cyc1, stb1, cyc3, stb3;
    logic stall1, ack1, err1, stall3, ack3, err3;
    logic [DW-1:0] rdata1, rdata3;
    logic [NR*DW-1:0] reg_in1, reg_in3, reg_out1, reg_out3;
    logic [NR-1:0] wr_pulse1, wr_pulse3;

    logic stall_m, ack_m, err_m;
    logic [DW-1:0] rdata_m;
    logic [NR*DW-1:0] reg_out_m;
    logic [NR-1:0] pulse_m;

    int check_count = 0;
    int fail_count = 0;
    int ack_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int pulse_cnt [2] = '{0, 0};
    int overlap_cnt = 0;

    logic [31:0] model [2][NR];
    logic [31:0] ro_val [2][NR];

    always #5 clk = ~clk;

    // Each instance only sees the bus while it is the selected target.
    assign cyc1 = cyc && !target;
    assign stb1 = stb && !target;
    assign cyc3 = cyc && target;
    assign stb3 = stb && target;

    assign stall_m   = target ? stall3 : stall1;
    assign ack_m     = target ? ack3 : ack1;
    assign err_m     = target ? err3 : err1;
    assign rdata_m   = target ? rdata3 : rdata1;
    assign reg_out_m = target ? reg_out3 : reg_out1;
    assign pulse_m   = target ? wr_pulse3 : wr_pulse1;

    wb_reg_slave #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_REGS (NR),
        .RO_MASK (RO1), .WAIT_STATES (1)
    ) dut1 (
        .clk (clk), .rst (rst), .cyc (cyc1), .stb (stb1), .we (we),
        .addr (addr), .wdata (wdata), .sel (sel), .stall (stall1),
        .ack (ack1), .rdata (rdata1), .err (err1), .reg_in (reg_in1),
        .reg_out (reg_out1), .wr_pulse (wr_pulse1)
    );

    wb_reg_slave #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_REGS (NR),
        .RO_MASK (RO3), .WAIT_STATES (3)
    ) dut3 (
        .clk (clk), .rst (rst), .cyc (cyc3), .stb (stb3), .we (we),
        .addr (addr), .wdata (wdata), .sel (sel), .stall (stall3),
        .ack (ack3), .rdata (rdata3), .err (err3), .reg_in (reg_in3),
        .reg_out (reg_out3), .wr_pulse (wr_pulse3)
    );

    always @(negedge clk) begin
        if (ack1) ack_cnt[0]++;
        if (ack3) ack_cnt[1]++;
        if (err1) err_cnt[0]++;
        if (err3) err_cnt[1]++;
        pulse_cnt[0] += $countones(wr_pulse1);
        pulse_cnt[1] += $countones(wr_pulse3);
        if ((ack1 && err1) || (ack3 && err3)) overlap_cnt++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic ro_bit(input int t, input int i);
        logic [NR-1:0] m;
        m = (t != 0) ? RO3 : RO1;
        return m[i];
    endfunction

    function automatic int wait_of(input int t);
        return (t != 0) ? 3 : 1;
    endfunction

    task automatic clearModel();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < NR; i++) model[t][i] = 32'h0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall1 | stall3), 32'h0);
        checkOutput({tag, "_ack"}, 32'(ack1 | ack3), 32'h0);
        checkOutput({tag, "_err"}, 32'(err1 | err3), 32'h0);
        checkOutput({tag, "_rdata1"}, rdata1, 32'h0);
        checkOutput({tag, "_rdata3"}, rdata3, 32'h0);
        checkOutput({tag, "_pulse"}, 32'({wr_pulse1, wr_pulse3}), 32'h0);
        for (int i = 0; i < NR; i++) begin
            checkOutput({tag, "_reg1"}, reg_out1[i*DW +: DW], 32'h0);
            checkOutput({tag, "_reg3"}, reg_out3[i*DW +: DW], 32'h0);
        end
    endtask

    // One complete master transaction on instance t, checked against the model.
    task automatic applyStimulus(input int t, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        int lat, idx, ack0, err0, pulse0;
        logic exp_err, obs_ack, obs_err;
        logic [31:0] obs_rdata, exp_rd;
        logic [NR-1:0] obs_pulse;
        idx = int'((a / 4) % NR);
        exp_err = (a % 4 != 0) || (a >= NR * 4) || (w && ro_bit(t, idx));
        target = (t != 0);
        #1;
        ack0 = ack_cnt[t];
        err0 = err_cnt[t];
        pulse0 = pulse_cnt[t];
        lat = 0;
        while (stall_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(negedge clk);
        stb = 1'b0;
        lat = 1;
        while (!(ack_m || err_m) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        obs_ack = ack_m;
        obs_err = err_m;
        obs_rdata = rdata_m;
        obs_pulse = pulse_m;
        cyc = 1'b0;
        we = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("latency", 32'(lat), 32'(wait_of(t) + 1));
        checkOutput("err", 32'(obs_err), 32'(exp_err));
        checkOutput("ack", 32'(obs_ack), 32'(!exp_err));
        if (exp_err) begin
            checkOutput("err_rdata", obs_rdata, 32'h0);
            checkOutput("err_pulse", 32'(obs_pulse), 32'h0);
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[t][idx][8*b +: 8] = d[8*b +: 8];
            checkOutput("wr_pulse", 32'(obs_pulse), 32'(1) << idx);
        end else begin
            exp_rd = ro_bit(t, idx) ? ro_val[t][idx] : model[t][idx];
            checkOutput("rdata", obs_rdata, exp_rd);
        end
        checkOutput("reg_out", reg_out_m[idx*DW +: DW], ro_bit(t, idx) ? 32'h0 : model[t][idx]);
        checkOutput("ack_count", 32'(ack_cnt[t] - ack0), 32'(!exp_err));
        checkOutput("err_count", 32'(err_cnt[t] - err0), 32'(exp_err));
        checkOutput("pulse_count", 32'(pulse_cnt[t] - pulse0), 32'(w && !exp_err));
    endtask

    // Drop cyc one cycle after the request is accepted by the 3-wait-state slave.
    task automatic abortTest();
        int ack0, err0, pulse0;
        target = 1'b1;
        @(negedge clk);
        #1;
        ack0 = ack_cnt[1]; err0 = err_cnt[1]; pulse0 = pulse_cnt[1];
        checkOutput("abort_idle", 32'(stall_m), 32'h0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'hA5A5_0F0F; sel = 4'hF;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("abort_ack", 32'(ack_cnt[1] - ack0), 32'h0);
        checkOutput("abort_err", 32'(err_cnt[1] - err0), 32'h0);
        checkOutput("abort_pulse", 32'(pulse_cnt[1] - pulse0), 32'h0);
        checkOutput("abort_reg", reg_out3[3*DW +: DW], model[1][3]);
        checkOutput("abort_stall", 32'(stall3), 32'h0);
    endtask

    task automatic resetInWaitTest();
        target = 1'b1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h04; sel = 4'hF;
        @(negedge clk);
        stb = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        clearModel();
        checkResetState("rst_wait");
        rst = 1'b0;
        cyc = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("rst_wait_noack", 32'(ack3 | err3), 32'h0);
    endtask

    // Hold stb for five cycles past the ack; the slave must stay stalled in DRAIN.
    task automatic holdStbTest();
        int lat, ack0;
        target = 1'b0;
        @(negedge clk);
        #1;
        ack0 = ack_cnt[0];
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h04; sel = 4'hF;
        @(negedge clk);
        lat = 1;
        while (!ack_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("hold_latency", 32'(lat), 32'd2);
        checkOutput("hold_rdata", rdata_m, model[0][1]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold_stall", 32'(stall_m), 32'h1);
            checkOutput("hold_noack", 32'(ack_m), 32'h0);
        end
        stb = 1'b0;
        cyc = 1'b0;
        @(negedge clk);
        checkOutput("hold_release", 32'(stall_m), 32'h0);
        #1;
        checkOutput("hold_ack_count", 32'(ack_cnt[0] - ack0), 32'h1);
    endtask

    initial begin
        int t, r;
        logic [31:0] a;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0; target = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) ro_val[k][i] = $urandom;
        ro_val[1][0] = 32'h1234_5678;
        for (int i = 0; i < NR; i++) begin
            reg_in1[i*DW +: DW] = ro_val[0][i];
            reg_in3[i*DW +: DW] = ro_val[1][i];
        end
        clearModel();
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic write/read");
        applyStimulus(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(0, 1'b0, 32'h04, 32'h0, 4'hF);

        $display("[TB] byte lanes");
        applyStimulus(0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(0, 1'b1, 32'h08, 32'h0000_0000, 4'b0101);
        checkOutput("sel_merge", reg_out1[2*DW +: DW], 32'hFF00_FF00);
        applyStimulus(0, 1'b1, 32'h0C, 32'h1122_3344, 4'b0000);

        $display("[TB] decode errors");
        applyStimulus(0, 1'b1, 32'h41, 32'h5555_AAAA, 4'hF);
        applyStimulus(0, 1'b1, 32'h100, 32'h5555_AAAA, 4'hF);
        applyStimulus(0, 1'b1, 32'h00, 32'h5555_AAAA, 4'hF);
        applyStimulus(1, 1'b1, 32'h3C, 32'h5555_AAAA, 4'hF);

        $display("[TB] read-only and wait states");
        applyStimulus(1, 1'b0, 32'h00, 32'h0, 4'hF);
        applyStimulus(0, 1'b0, 32'h00, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF);

        $display("[TB] abort and reset");
        abortTest();
        applyStimulus(1, 1'b0, 32'h0C, 32'h0, 4'hF);
        resetInWaitTest();
        applyStimulus(1, 1'b0, 32'h0C, 32'h0, 4'hF);

        $display("[TB] strobe held past ack");
        applyStimulus(0, 1'b1, 32'h04, 32'h0BAD_F00D, 4'hF);
        holdStbTest();

        $display("[TB] random accesses");
        for (int n = 0; n < 120; n++) begin
            t = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7) a = 32'($urandom_range(0, NR - 1) * 4);
            else if (r == 7) a = 32'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 32'(NR * 4 + $urandom_range(0, 255) * 4);
            else a = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'(NR * 4 - 4);
            applyStimulus(t, $urandom_range(0, 1) != 0, a, $urandom, 4'($urandom_range(0, 15)));
        end

        checkOutput("ack_err_overlap", 32'(overlap_cnt), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
